// File: rtl/program_loader.sv
// program_loader: receives a byte stream over a valid/ready handshake and
// assembles big-endian 20-bit instruction words. It writes the words to
// consecutive addresses of the 1024 x 20 program memory, starting at
// BASE_ADDR and wrapping from 1023 to 0. cpu_hold stays high for the whole
// load, and also after an aborted load, so a partial program never runs.
//
// Stream format:
//   HDR0 (count[9:8] in bits [1:0]), HDR1 (count[7:0]),
//   then count+1 words of three bytes each (B0 low nibble, B1, B2).
//
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum
// byte. The checksum is the XOR of both header bytes and every data byte.
// A mismatch ends the load in ERR. Words already written are kept.
module program_loader #(
    parameter logic [9:0] BASE_ADDR     = 10'd0,
    parameter bit         STRICT_NIBBLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [9:0]  mem_addr,
    output logic [19:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  ptr_reg, ptr_next;              // address of the next word
    logic [9:0]  remaining_reg, remaining_next;  // words left after the current one
    logic [19:0] word_reg, word_next;            // word being assembled
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_reg, xor_next;              // running checksum
`endif

    logic        rx_ready_reg, mem_we_reg, cpu_hold_reg, busy_reg, done_reg, err_reg;
    logic [9:0]  mem_addr_reg;
    logic [19:0] mem_wdata_reg;
    logic        rx_ready_next, busy_next, hold_next;
    logic        xfer;

    assign rx_ready  = rx_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    // A byte moves only when the registered ready and the sender's valid coincide.
    assign xfer = rx_valid && rx_ready_reg;

    // Next-state, pointer, counter and word-assembly logic.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        word_next      = word_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next     = S_HDR0;
                    ptr_next       = BASE_ADDR;
                    remaining_next = 10'd0;
                    word_next      = 20'd0;
                end
            end
            S_HDR0: begin
                if (xfer) begin
                    remaining_next = {rx_data[1:0], remaining_reg[7:0]};
                    state_next     = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    remaining_next[7:0] = rx_data;
                    state_next          = S_B0;
                end
            end
            S_B0: begin
                if (xfer) begin
                    if (STRICT_NIBBLE && (rx_data[7:4] != 4'd0)) begin
                        state_next = S_ERR;
                    end else begin
                        word_next[19:16] = rx_data[3:0];
                        state_next       = S_B1;
                    end
                end
            end
            S_B1: begin
                if (xfer) begin
                    word_next[15:8] = rx_data;
                    state_next      = S_B2;
                end
            end
            S_B2: begin
                if (xfer) begin
                    word_next[7:0] = rx_data;
                    state_next     = S_WRITE;
                end
            end
            S_WRITE: begin
                ptr_next = ptr_reg + 10'd1;
                if (remaining_reg == 10'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_next = S_CHK;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    remaining_next = remaining_reg - 10'd1;
                    state_next     = S_B0;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_next = (rx_data == xor_reg) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR: cleared on start, then folds in every header and data byte.
    always_comb begin
        xor_next = xor_reg;
        if ((state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR) && start)
            xor_next = 8'd0;
        else if (xfer && state_reg != S_CHK)
            xor_next = xor_reg ^ rx_data;
    end
`endif

    // Output values for the state being entered. The outputs are registered.
    always_comb begin
        rx_ready_next = 1'b0;
        busy_next     = 1'b1;
        hold_next     = 1'b1;
        case (state_next)
            S_HDR0, S_HDR1, S_B0, S_B1, S_B2: rx_ready_next = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: rx_ready_next = 1'b1;
`endif
            S_IDLE, S_DONE: begin
                busy_next = 1'b0;
                hold_next = 1'b0;
            end
            S_ERR: busy_next = 1'b0;
            default: ;
        endcase
    end

    // State and registered outputs. The async reset drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= BASE_ADDR;
            remaining_reg <= 10'd0;
            word_reg      <= 20'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_reg       <= 8'd0;
`endif
            rx_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= 20'd0;
            cpu_hold_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            word_reg      <= word_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_reg       <= xor_next;
`endif
            rx_ready_reg  <= rx_ready_next;
            mem_we_reg    <= (state_next == S_WRITE);
            if (state_next == S_WRITE) begin
                mem_addr_reg  <= ptr_reg;
                mem_wdata_reg <= word_next;
            end
            cpu_hold_reg  <= hold_next;
            busy_reg      <= busy_next;
            done_reg      <= (state_next == S_DONE);
            err_reg       <= (state_next == S_ERR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader. Two instances share one byte stream.
// dut0 has BASE_ADDR=0 and dut1 has BASE_ADDR=1023, so address wrap is
// checked on every load. The bench runs fixed vectors, hand sequences
// and random loads. A word-level model derives the expected writes.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;

    logic        rdy0, we0, hold0, busy0, done0, err0;
    logic [9:0]  addr0;
    logic [19:0] wd0;
    logic        rdy1, we1, hold1, busy1, done1, err1;
    logic [9:0]  addr1;
    logic [19:0] wd1;

    int total = 0;
    int bad   = 0;
    int load_no = 0;

    logic [29:0] wr_q0[$];
    logic [29:0] wr_q1[$];

    logic [7:0]  stream_q[$];
    int          n_send;
    logic [19:0] exp_words[$];
    logic        exp_done, exp_err, send_chk;
    logic [7:0]  chk_byte;

    typedef struct {
        logic [63:0] bytes;   // first byte in bits [63:56]
        int          len;
        int          nsend;
        int          gap;
        int          nw;
        logic [19:0] w0;
        logic [19:0] w1;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    program_loader #(.BASE_ADDR(10'd0), .STRICT_NIBBLE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy0), .mem_addr(addr0), .mem_wdata(wd0), .mem_we(we0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0)
    );

    program_loader #(.BASE_ADDR(10'd1023), .STRICT_NIBBLE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy1), .mem_addr(addr1), .mem_wdata(wd1), .mem_we(we1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    // Record every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (we0) wr_q0.push_back({addr0, wd0});
        if (we1) wr_q1.push_back({addr1, wd1});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flag order: {rx_ready, mem_we, cpu_hold, busy, done, err}
    task automatic check_outs(input string tag, input logic e_rdy, input logic e_we,
                              input logic e_hold, input logic e_busy,
                              input logic e_done, input logic e_err);
        chk({tag, ".flags0"}, 32'({rdy0, we0, hold0, busy0, done0, err0}),
            32'({e_rdy, e_we, e_hold, e_busy, e_done, e_err}));
        chk({tag, ".flags1"}, 32'({rdy1, we1, hold1, busy1, done1, err1}),
            32'({e_rdy, e_we, e_hold, e_busy, e_done, e_err}));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Idle for gap cycles with the CPU held, then hand one byte over.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            chk("gap_hold_busy", 32'({hold0, busy0, hold1, busy1}), 32'hF);
            @(posedge clk); #1;
        end
        n = 0;
        while (!rdy0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy0) begin
            chk("ready_timeout", 32'(rdy0), 32'd1);
            return;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        n = exp_words.size();
        chk({tag, ".nwr0"}, 32'(wr_q0.size()), 32'(n));
        chk({tag, ".nwr1"}, 32'(wr_q1.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < wr_q0.size()) begin
                chk({tag, ".addr0"}, 32'(wr_q0[k][29:20]), 32'(k % 1024));
                chk({tag, ".data0"}, 32'(wr_q0[k][19:0]), 32'(exp_words[k]));
            end
            if (k < wr_q1.size()) begin
                chk({tag, ".addr1"}, 32'(wr_q1[k][29:20]), 32'((1023 + k) % 1024));
                chk({tag, ".data1"}, 32'(wr_q1[k][19:0]), 32'(exp_words[k]));
            end
        end
        if (n > 0) begin
            chk({tag, ".hold_addr0"}, 32'(addr0), 32'((n - 1) % 1024));
            chk({tag, ".hold_addr1"}, 32'(addr1), 32'((1023 + n - 1) % 1024));
        end
    endtask

    // Full load: start, stream n_send bytes (plus the checksum when enabled), then check.
    task automatic run_load(input int gap, input string tag);
        wr_q0.delete();
        wr_q1.delete();
        pulse_start();
        check_outs({tag, ".start"}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n_send; i++) send_byte(stream_q[i], gap);
        if (send_chk) send_byte(chk_byte, gap);
        repeat (2) @(posedge clk);
        #1;
        check_outs({tag, ".end"}, 1'b0, 1'b0, exp_err, 1'b0, exp_done, exp_err);
        compare_writes(tag);
        load_no++;
        $display("load %0d %s: bytes=%0d words=%0d done=%0b err=%0b",
                 load_no, tag, n_send, wr_q0.size(), done0, err0);
    endtask

    function automatic logic [7:0] stream_xor(input int upto);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < upto; i++) x ^= stream_q[i];
        return x;
    endfunction

    // Word-level model: parse the stream and decide the writes and the final status.
    function automatic void model_compute();
        logic [7:0] h0, h1, b0, b1, b2, x;
        int n;
        exp_words.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        send_chk = 1'b0;
        h0 = stream_q[0];
        h1 = stream_q[1];
        n  = int'({h0[1:0], h1}) + 1;
        x  = h0 ^ h1;
        n_send = 2;
        for (int i = 0; i < n; i++) begin
            b0 = stream_q[2 + 3 * i];
            n_send++;
            if (b0[7:4] != 4'd0) begin
                exp_err = 1'b1;
                return;
            end
            b1 = stream_q[3 + 3 * i];
            b2 = stream_q[4 + 3 * i];
            n_send += 2;
            exp_words.push_back({b0[3:0], b1, b2});
            x ^= b0 ^ b1 ^ b2;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_chk = 1'b1;
        if (chk_byte == x) exp_done = 1'b1;
        else               exp_err  = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endfunction

    task automatic gen_random(input int count, input int err_pct);
        logic [7:0] b0;
        stream_q.delete();
        stream_q.push_back({6'($urandom), count[9:8]});
        stream_q.push_back(count[7:0]);
        for (int i = 0; i <= count; i++) begin
            if ($urandom_range(99) < err_pct) b0 = 8'($urandom_range(255, 16));
            else                              b0 = {4'd0, 4'($urandom)};
            stream_q.push_back(b0);
            stream_q.push_back(8'($urandom));
            stream_q.push_back(8'($urandom));
        end
        chk_byte = stream_xor(stream_q.size());
        if ($urandom_range(4) == 0) chk_byte ^= 8'($urandom_range(255, 1));
    endtask

    task automatic load_vector(input vec_t v);
        logic [63:0] bb;
        bb = v.bytes;
        stream_q.delete();
        for (int i = 0; i < v.len; i++) stream_q.push_back(bb[63 - 8 * i -: 8]);
        n_send = v.nsend;
        exp_words.delete();
        if (v.nw > 0) exp_words.push_back(v.w0);
        if (v.nw > 1) exp_words.push_back(v.w1);
        exp_done = v.done;
        exp_err  = v.err;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_chk = !v.err;
        chk_byte = stream_xor(v.len);
`else
        send_chk = 1'b0;
`endif
    endtask

    initial begin
        //            bytes                   len nsend gap nw  w0         w1         done  err
        vecs[0] = '{64'h00010ABCDE012345,     8,  8,    0,  2,  20'hABCDE, 20'h12345, 1'b1, 1'b0};
        vecs[1] = '{64'h00010ABCDE012345,     8,  8,    3,  2,  20'hABCDE, 20'h12345, 1'b1, 1'b0};
        vecs[2] = '{64'h0001000007000008,     8,  8,    0,  2,  20'h00007, 20'h00008, 1'b1, 1'b0};
        vecs[3] = '{64'hFC000FFFFF000000,     5,  5,    1,  1,  20'hFFFFF, 20'h00000, 1'b1, 1'b0};
        vecs[4] = '{64'h00001ABCDE000000,     5,  3,    0,  0,  20'h00000, 20'h00000, 1'b0, 1'b1};
        vecs[5] = '{64'h00000ABCDE000000,     5,  5,    2,  1,  20'hABCDE, 20'h00000, 1'b1, 1'b0};
        vecs[6] = '{64'h00010F00000000FF,     8,  8,    1,  2,  20'hF0000, 20'h000FF, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.addr0", 32'(addr0), 32'd0);
        chk("reset.addr1", 32'(addr1), 32'd1023);
        chk("reset.wdata", 32'({wd0, wd1}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fixed vectors
        for (int v = 0; v < 7; v++) begin
            load_vector(vecs[v]);
            run_load(vecs[v].gap, $sformatf("vec%0d", v));
            if (v == 4) begin
                // Bytes offered in ERR are ignored and the error state holds.
                rx_valid = 1'b1;
                rx_data  = 8'hBC;
                repeat (4) @(posedge clk);
                #1;
                rx_valid = 1'b0;
                check_outs("err_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                chk("err_hold.nwr", 32'(wr_q0.size() + wr_q1.size()), 32'd0);
            end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // A wrong checksum ends in ERR, but the write already issued stands.
        load_vector(vecs[5]);
        chk_byte = 8'h69;
        exp_done = 1'b0;
        exp_err  = 1'b1;
        run_load(0, "bad_chk");
`endif

        // A start while busy is ignored.
        load_vector(vecs[5]);
        wr_q0.delete();
        wr_q1.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        pulse_start();
        check_outs("start_busy", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h0A, 0);
        send_byte(8'hBC, 0);
        send_byte(8'hDE, 0);
        if (send_chk) send_byte(chk_byte, 0);
        repeat (2) @(posedge clk);
        #1;
        check_outs("start_busy.end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        compare_writes("start_busy");
        $display("load start_busy: words=%0d done=%0b", wr_q0.size(), done0);

        // An async reset in the middle of word 2 drops that word.
        load_vector(vecs[0]);
        wr_q0.delete();
        wr_q1.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stream_q[i], 0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_rst.addr0", 32'(addr0), 32'd0);
        chk("async_rst.addr1", 32'(addr1), 32'd1023);
        chk("async_rst.wdata", 32'({wd0, wd1}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("async_rst.nwr", 32'(wr_q0.size()), 32'd1);
        check_outs("async_rst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("load async_rst: words before reset=%0d", wr_q0.size());
        run_load(0, "after_rst");

        // Random loads against the model
        for (int r = 0; r < 30; r++) begin
            gen_random($urandom_range(5), 10);
            model_compute();
            run_load($urandom_range(2), $sformatf("rand%0d", r));
        end

        // Full 1024-word load: every address is written exactly once.
        gen_random(1023, 0);
        model_compute();
        run_load(0, "full1024");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side companion to the CPU's instruction fetch path: receives a byte stream over a valid/ready handshake, assembles 20-bit instruction words and writes them sequentially into the 1024 x 20 memory.
- Holds the CPU (cpu_hold) while a load is in progress.
- Sits beside the CPU top. Its mem_* outputs are muxed onto the memory write port while cpu_hold is high.

Parameters:
- BASE_ADDR, 10'd0, first memory address written; later words go to successive addresses.
- STRICT_NIBBLE, 1, when 1 a first data byte with a nonzero upper nibble is a format error; when 0 the upper nibble is ignored.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERR
- rx_valid  input  1  rx_data is valid this cycle
- rx_data  input  8  stream byte
- rx_ready  output  1  loader accepts a byte on this edge when rx_valid is also high
- mem_addr  output  10  memory write address
- mem_wdata  output  20  memory write data
- mem_we  output  1  memory write strobe, one cycle per word
- cpu_hold  output  1  stalls the CPU (fetch/pc_write gated externally)
- busy  output  1  load in progress
- done  output  1  last load completed successfully (sticky)
- err  output  1  last load aborted on a format or checksum error (sticky)

Behaviour:
- Reset (async, any time, including mid-load):
  - state=IDLE.
  - All outputs 0; mem_addr=BASE_ADDR, mem_wdata=0.
  - Word counter and assembly registers cleared.
  - Any partially received word is discarded; no mem_we is issued.
- States: IDLE, HDR0, HDR1, B0, B1, B2, WRITE, [CHK], DONE, ERR.
- A byte transfer is rx_valid && rx_ready sampled at the rising edge.
- rx_ready is 1 only in HDR0, HDR1, B0, B1, B2 (and CHK); otherwise 0. With rx_valid low the state holds indefinitely.
- start in IDLE/DONE/ERR:
  - Next state HDR0.
  - Clear done and err; busy=1, cpu_hold=1.
  - Word pointer = BASE_ADDR.
- Header:
  - HDR0 byte bits[1:0] = count[9:8]; bits[7:2] are ignored.
  - HDR1 byte = count[7:0].
  - Words to load N = count+1, range 1..1024.
- Word assembly, big-endian:
  - B0 byte[3:0] -> word[19:16]. If STRICT_NIBBLE and byte[7:4] != 0, go to ERR.
  - B1 -> word[15:8].
  - B2 -> word[7:0], then WRITE.
- WRITE (exactly one cycle, no byte accepted):
  - mem_we=1, mem_addr=pointer, mem_wdata=word.
  - Next cycle: pointer+1 mod 1024 (wraps 1023 -> 0); remaining count decrements.
  - If words remain, go to B0; else go to CHK when enabled, otherwise DONE.
- Latency: mem_we asserts the cycle after the B2 byte is accepted. Minimum 4 cycles per word.
- DONE: busy=0, cpu_hold=0, done=1 held until the next start or rst.
- ERR:
  - busy=0, err=1, cpu_hold stays 1 so a partial program never runs.
  - Leave only by start or rst.
- mem_we is 0 in every state except WRITE. mem_addr/mem_wdata hold their last values outside WRITE.
- start while busy is ignored. rx_valid outside the receiving states is ignored.
- Writes wrap past 1023 silently; a 1024-word load from any BASE_ADDR overwrites the whole memory exactly once.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers both header bytes and every data byte.
  - After the last WRITE the state goes to CHK and accepts one byte.
  - If the byte equals the running XOR, go to DONE; otherwise go to ERR.
  - All memory writes already issued stand.
- Undefined: no CHK state, no XOR register; the last WRITE goes directly to DONE.

Test Plan:
- BASE_ADDR=0, start, bytes 00 01 0A BC DE 01 23 45 with rx_valid continuous:
  - mem_we pulses with (0, 20'hABCDE) and then (1, 20'h12345).
  - done=1, cpu_hold=0, err=0.
- Same stream with rx_valid low for 3 cycles between every byte -> identical writes; cpu_hold stays 1 until DONE.
- BASE_ADDR=1023, stream 00 01 00 00 07 00 00 08 -> writes (1023, 20'h00007) then (0, 20'h00008).
- STRICT_NIBBLE=1, stream 00 00 1A BC DE:
  - err=1, no mem_we, cpu_hold=1, rx_ready=0.
  - A subsequent start clears err, and a valid stream reaches DONE.
- Assert rst after the B1 byte of word 2 -> no second mem_we, all outputs 0 immediately (async). A new start loads correctly from BASE_ADDR.
- With PROGRAM_LOADER_CHECKSUM_EN:
  - Stream 00 00 0A BC DE then checksum 0x00^0x00^0x0A^0xBC^0xDE = 0x68 -> done=1.
  - Checksum 0x69 -> err=1; the write (0, 20'hABCDE) has still occurred.
